// File: rtl/async_reg_bus_port.sv
// async_reg_bus_port: control register with a byte-masked valid/ready access port,
// sticky hardware set inputs and a single-entry registered response buffer.
module async_reg_bus_port #(
    parameter int unsigned       WIDTH       = 32,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
    parameter logic [WIDTH-1:0]  WRITE_MASK  = '1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [WIDTH-1:0]     req_wdata,
    input  logic [WIDTH/8-1:0]   req_mask,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [WIDTH-1:0]     resp_rdata,
    output logic                 resp_was_write,
    input  logic [WIDTH-1:0]     hw_set,
    output logic [WIDTH-1:0]     q
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    logic             acc;
    logic [WIDTH-1:0] bm;
    logic [WIDTH-1:0] q_n;

    // Ready depends only on buffer occupancy, consumer ready and reset.
    assign resp_valid = (state == FULL);
    assign req_ready  = ~rst & (~resp_valid | resp_ready);
    assign acc        = req_valid & req_ready;

    // Byte-lane enables expanded to bits, restricted to the writable bits.
    always_comb begin
        bm = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            bm[i] = req_mask[i/8] & WRITE_MASK[i];
        end
    end

    // Register next state: bus write first, then sticky hardware sets on top.
    always_comb begin
        q_n = q;
        if (acc && req_write) begin
            q_n = (q & ~bm) | (req_wdata & bm);
        end
        q_n = q_n | hw_set;
    end

    // Register contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_VALUE;
        end else begin
            q <= q_n;
        end
    end

    // Response buffer: captures the pre-update value on every accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= EMPTY;
            resp_rdata     <= '0;
            resp_was_write <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc) begin
                        state          <= FULL;
                        resp_rdata     <= q;
                        resp_was_write <= req_write;
                    end
                end
                FULL: begin
                    if (acc) begin
                        resp_rdata     <= q;
                        resp_was_write <= req_write;
                    end else if (resp_ready) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_async_reg_bus_port.sv
// Directed testbench for async_reg_bus_port. Inputs change 1 time unit after
// each rising edge; outputs are checked at the same point, before new inputs.
module tb_async_reg_bus_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_wdata;
    logic [3:0]  req_mask;
    logic        resp_valid, resp_ready, resp_was_write;
    logic [31:0] resp_rdata, hw_set, q;

    logic        w_req_valid, w_req_ready, w_req_write;
    logic [31:0] w_req_wdata;
    logic [3:0]  w_req_mask;
    logic        w_resp_valid, w_resp_ready, w_resp_was_write;
    logic [31:0] w_resp_rdata, w_hw_set, w_q;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    async_reg_bus_port #(
        .WIDTH(32), .RESET_VALUE(32'h0000_00A5), .WRITE_MASK(32'hFFFF_FFFF)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_wdata(req_wdata), .req_mask(req_mask),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_was_write(resp_was_write),
        .hw_set(hw_set), .q(q)
    );

    async_reg_bus_port #(
        .WIDTH(32), .RESET_VALUE(32'h0000_0000), .WRITE_MASK(32'h0000_FFFF)
    ) dut_wm (
        .clk(clk), .rst(rst),
        .req_valid(w_req_valid), .req_ready(w_req_ready), .req_write(w_req_write),
        .req_wdata(w_req_wdata), .req_mask(w_req_mask),
        .resp_valid(w_resp_valid), .resp_ready(w_resp_ready),
        .resp_rdata(w_resp_rdata), .resp_was_write(w_resp_was_write),
        .hw_set(w_hw_set), .q(w_q)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic w, input logic [31:0] d,
                         input logic [3:0] m, input logic rr);
        req_valid  = v;
        req_write  = w;
        req_wdata  = d;
        req_mask   = m;
        resp_ready = rr;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 4'h0, 1'b0);
        hw_set = '0;
        w_req_valid = 1'b0; w_req_write = 1'b0; w_req_wdata = '0; w_req_mask = '0;
        w_resp_ready = 1'b1; w_hw_set = '0;
        tick(); tick();
        checks++; if (q !== 32'h0000_00A5) begin errors++; $display("FAIL reset_q got=%h exp=%h", q, 32'h0000_00A5); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
        checks++; if (resp_rdata !== 32'h0 || resp_was_write !== 1'b0) begin errors++; $display("FAIL reset_resp got=%h/%b exp=0/0", resp_rdata, resp_was_write); end
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL release_req_ready got=%b exp=1", req_ready); end
        // Fill the buffer and change q, then reset asynchronously mid-stream.
        drive(1'b1, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b0);
        tick();
        checks++; if (resp_valid !== 1'b1 || q !== 32'hDEAD_BEEF) begin errors++; $display("FAIL pre_reset got=%b/%h exp=1/deadbeef", resp_valid, q); end
        drive(1'b0, 1'b0, 32'h0, 4'h0, 1'b0);
        #2 rst = 1'b1;
        #1;
        checks++; if (q !== 32'h0000_00A5) begin errors++; $display("FAIL midreset_q got=%h exp=000000a5", q); end
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL midreset_flags got=%b/%b exp=0/0", resp_valid, req_ready); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL midreset_rdata got=%h exp=0", resp_rdata); end
        tick();
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rerelease_req_ready got=%b exp=1", req_ready); end
    endtask

    task automatic test_masked_write();
        drive(1'b1, 1'b1, 32'h1122_3344, 4'hF, 1'b1);
        tick();
        checks++; if (q !== 32'h1122_3344) begin errors++; $display("FAIL load_q got=%h exp=11223344", q); end
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0000_00A5 || resp_was_write !== 1'b1) begin errors++; $display("FAIL load_resp got=%b/%h/%b exp=1/000000a5/1", resp_valid, resp_rdata, resp_was_write); end
        drive(1'b1, 1'b1, 32'hAABB_CCDD, 4'b0101, 1'b1);
        tick();
        checks++; if (resp_rdata !== 32'h1122_3344 || resp_was_write !== 1'b1) begin errors++; $display("FAIL swap_resp got=%h/%b exp=11223344/1", resp_rdata, resp_was_write); end
        checks++; if (q !== 32'h11BB_33DD) begin errors++; $display("FAIL masked_q got=%h exp=11bb33dd", q); end
        drive(1'b1, 1'b0, 32'h0, 4'h0, 1'b1);
        tick();
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h11BB_33DD || resp_was_write !== 1'b0) begin errors++; $display("FAIL readback got=%b/%h/%b exp=1/11bb33dd/0", resp_valid, resp_rdata, resp_was_write); end
        // Zero-mask write: accepted with a response, no bits change.
        drive(1'b1, 1'b1, 32'hFFFF_FFFF, 4'h0, 1'b1);
        tick();
        checks++; if (resp_valid !== 1'b1 || resp_was_write !== 1'b1 || q !== 32'h11BB_33DD) begin errors++; $display("FAIL zero_mask got=%b/%b/%h exp=1/1/11bb33dd", resp_valid, resp_was_write, q); end
        drive(1'b0, 1'b0, 32'h0, 4'h0, 1'b1);
        tick();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL drain got=%b exp=0", resp_valid); end
    endtask

    task automatic test_backpressure();
        drive(1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
        tick();
        // A pending full-mask write of 0 must not be accepted while stalled.
        drive(1'b1, 1'b1, 32'h0, 4'hF, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (req_ready !== 1'b0 || resp_valid !== 1'b1) begin errors++; $display("FAIL stall_flags[%0d] got=%b/%b exp=0/1", i, req_ready, resp_valid); end
            checks++; if (resp_rdata !== 32'h11BB_33DD || resp_was_write !== 1'b0 || q !== 32'h11BB_33DD) begin errors++; $display("FAIL stall_hold[%0d] got=%h/%b/%h exp=11bb33dd/0/11bb33dd", i, resp_rdata, resp_was_write, q); end
            tick();
        end
        resp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL unstall_ready got=%b exp=1", req_ready); end
        tick();
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h11BB_33DD || resp_was_write !== 1'b1 || q !== 32'h0) begin errors++; $display("FAIL unstall_accept got=%b/%h/%b/%h exp=1/11bb33dd/1/0", resp_valid, resp_rdata, resp_was_write, q); end
        drive(1'b0, 1'b0, 32'h0, 4'h0, 1'b1);
        tick();
    endtask

    task automatic test_hw_set_write();
        drive(1'b1, 1'b1, 32'hFFFF_FFFF, 4'hF, 1'b1);
        tick();
        drive(1'b1, 1'b1, 32'h0, 4'hF, 1'b1);
        hw_set = 32'h8000_0001;
        tick();
        checks++; if (q !== 32'h8000_0001 || resp_rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL hwset_vs_write got=%h/%h exp=80000001/ffffffff", q, resp_rdata); end
        drive(1'b0, 1'b0, 32'h0, 4'h0, 1'b1);
        hw_set = 32'h0000_0100;
        tick();
        hw_set = '0;
        tick();
        checks++; if (q !== 32'h8000_0101) begin errors++; $display("FAIL hwset_only got=%h exp=80000101", q); end
    endtask

    task automatic test_write_mask();
        w_req_valid = 1'b1; w_req_write = 1'b1; w_req_wdata = 32'hFFFF_FFFF; w_req_mask = 4'hF;
        tick();
        checks++; if (w_q !== 32'h0000_FFFF) begin errors++; $display("FAIL wm_write got=%h exp=0000ffff", w_q); end
        w_req_valid = 1'b0;
        w_hw_set = 32'h0001_0000;
        tick();
        w_hw_set = '0;
        checks++; if (w_q !== 32'h0001_FFFF) begin errors++; $display("FAIL wm_hwset got=%h exp=0001ffff", w_q); end
        w_req_valid = 1'b1; w_req_wdata = 32'h0;
        tick();
        w_req_valid = 1'b0;
        checks++; if (w_q !== 32'h0001_0000 || w_resp_rdata !== 32'h0001_FFFF || w_resp_valid !== 1'b1 || w_resp_was_write !== 1'b1) begin errors++; $display("FAIL wm_clear got=%h/%h/%b/%b exp=00010000/0001ffff/1/1", w_q, w_resp_rdata, w_resp_valid, w_resp_was_write); end
        checks++; if (w_req_ready !== 1'b1) begin errors++; $display("FAIL wm_ready got=%b exp=1", w_req_ready); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        drive(1'b1, 1'b1, 32'h0, 4'hF, 1'b1);
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 32'h0, 4'h0, 1'b1);
            hw_set = 32'(1) << i;
            #1;
            checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d] got=%b exp=1", i, req_ready); end
            tick();
            exp = (32'(1) << i) - 32'(1);
            checks++; if (resp_valid !== 1'b1 || resp_rdata !== exp || resp_was_write !== 1'b0) begin errors++; $display("FAIL stream_resp[%0d] got=%b/%h/%b exp=1/%h/0", i, resp_valid, resp_rdata, resp_was_write, exp); end
        end
        drive(1'b0, 1'b0, 32'h0, 4'h0, 1'b1);
        hw_set = '0;
        tick();
        checks++; if (resp_valid !== 1'b0 || q !== 32'h0000_00FF) begin errors++; $display("FAIL stream_end got=%b/%h exp=0/000000ff", resp_valid, q); end
    endtask

    initial begin
        test_reset();
        test_masked_write();
        test_backpressure();
        test_hw_set_write();
        test_write_mask();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
